pid_ctrl: RTL

Parametrised, pipelined successor to the balance-loop PID controller. It takes pitch and pitch-rate samples qualified by `vld` and produces a saturated signed motor-control word. The output carries a `cntrl_vld` strobe, and the integrator has optional conditional-integration anti-windup. It sits between the inertial interface and the motor-balance/PWM logic and also provides the soft-start timer.

---
 rtl/pid_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pid_ctrl.sv
// pid_ctrl: two-stage PID (vld sampled at edge N -> cntrl_vld after edge N+1), no backpressure, plus soft-start timer.
// Define PID_ANTIWINDUP_EN to freeze the integrator while the output is saturated in the direction of the error.
module pid_ctrl #(
    parameter int PTCH_W   = 16,
    parameter int ERR_W    = 10,
    parameter int P_COEFF  = 9,
    parameter int D_SHIFT  = 6,
    parameter int I_SHIFT  = 6,
    parameter int INTEG_W  = 18,
    parameter int OUT_W    = 12,
    parameter int TMR_W    = 27,
    parameter int SS_W     = 8,
    parameter int FAST_SIM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic [PTCH_W-1:0] ptch,
    input  logic [PTCH_W-1:0] ptch_rt,
    input  logic              pwr_up,
    input  logic              rider_off,
    output logic [OUT_W-1:0]  PID_cntrl,
    output logic              cntrl_vld,
    output logic [SS_W-1:0]   ss_tmr
);

    localparam int SUM_W = INTEG_W + 2;
    localparam int IA_W  = INTEG_W + 1;
    localparam int I_SH  = (FAST_SIM != 0) ? 1 : I_SHIFT;
    localparam int STEP_I = (FAST_SIM != 0) ? 256 : 1;

    localparam logic [ERR_W-1:0]   ERR_HI    = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0]   ERR_LO    = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [PTCH_W-1:0]  PT_HI     = {{(PTCH_W-ERR_W){1'b0}}, ERR_HI};
    localparam logic [PTCH_W-1:0]  PT_LO     = {{(PTCH_W-ERR_W){1'b1}}, ERR_LO};
    localparam logic [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
    localparam logic [INTEG_W-1:0] INTEG_MIN = {1'b1, {(INTEG_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]   OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [SUM_W-1:0]   P_GAIN    = SUM_W'(P_COEFF);
    localparam logic [TMR_W-1:0]   TMR_STEP  = TMR_W'(STEP_I);

    logic [INTEG_W-1:0] integ_q, integ_d;
    logic [SUM_W-1:0]   pterm_q, pterm_d;
    logic [SUM_W-1:0]   dterm_q, dterm_d;
    logic               s1_vld_q;
    logic [OUT_W-1:0]   pid_q, pid_d;
    logic               cvld_q;
    logic [TMR_W-1:0]   cnt_q, cnt_d;

    logic [ERR_W-1:0]   err;
    logic [SUM_W-1:0]   err_x;
    logic [PTCH_W-1:0]  rt_sh;
    logic [IA_W-1:0]    integ_add;
    logic [INTEG_W-1:0] integ_sat;
    logic [INTEG_W-1:0] iterm;
    logic [SUM_W-1:0]   sum;
    logic               aw_hold;

    always_comb begin
        if ($signed(ptch) > $signed(PT_HI)) begin
            err = ERR_HI;
        end else if ($signed(ptch) < $signed(PT_LO)) begin
            err = ERR_LO;
        end else begin
            err = ptch[ERR_W-1:0];
        end
    end

    assign err_x   = {{(SUM_W-ERR_W){err[ERR_W-1]}}, err};
    assign pterm_d = SUM_W'($signed(err_x) * $signed(P_GAIN));
    assign rt_sh   = PTCH_W'($signed(ptch_rt) >>> D_SHIFT);
    assign dterm_d = -{{(SUM_W-PTCH_W){rt_sh[PTCH_W-1]}}, rt_sh};

    // One extra bit of headroom so overflow shows up in the top two bits instead of wrapping.
    assign integ_add = {integ_q[INTEG_W-1], integ_q} + {{(IA_W-ERR_W){err[ERR_W-1]}}, err};

    always_comb begin
        case (integ_add[IA_W-1:IA_W-2])
            2'b01:   integ_sat = INTEG_MAX;
            2'b10:   integ_sat = INTEG_MIN;
            default: integ_sat = integ_add[INTEG_W-1:0];
        endcase
    end

`ifdef PID_ANTIWINDUP_EN
    assign aw_hold = ((pid_q == OUT_MAX) && !err[ERR_W-1] && (|err)) ||
                     ((pid_q == OUT_MIN) && err[ERR_W-1]);
`else
    assign aw_hold = 1'b0;
`endif

    always_comb begin
        integ_d = integ_q;
        if (rider_off) begin
            integ_d = '0;
        end else if (vld && !aw_hold) begin
            integ_d = integ_sat;
        end
    end

    // Stage 2 sees the integrator already updated by the sample now sitting in stage 1.
    assign iterm = INTEG_W'($signed(integ_q) >>> I_SH);
    assign sum   = pterm_q + {{(SUM_W-INTEG_W){iterm[INTEG_W-1]}}, iterm} + dterm_q;

    always_comb begin
        if (!sum[SUM_W-1] && (|sum[SUM_W-2:OUT_W-1])) begin
            pid_d = OUT_MAX;
        end else if (sum[SUM_W-1] && !(&sum[SUM_W-2:OUT_W-1])) begin
            pid_d = OUT_MIN;
        end else begin
            pid_d = sum[OUT_W-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pwr_up) begin
            cnt_d = '0;
        end else if (!(&cnt_q[TMR_W-1 -: SS_W])) begin
            cnt_d = cnt_q + TMR_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_q  <= '0;
            pterm_q  <= '0;
            dterm_q  <= '0;
            s1_vld_q <= 1'b0;
            pid_q    <= '0;
            cvld_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            integ_q  <= integ_d;
            s1_vld_q <= vld;
            cvld_q   <= s1_vld_q;
            cnt_q    <= cnt_d;
            if (vld) begin
                pterm_q <= pterm_d;
                dterm_q <= dterm_d;
            end
            if (s1_vld_q) begin
                pid_q <= pid_d;
            end
        end
    end

    assign PID_cntrl = pid_q;
    assign cntrl_vld = cvld_q;
    assign ss_tmr    = cnt_q[TMR_W-1 -: SS_W];

endmodule
